shift_out_tx: RTL and testbench

//  Parallel-to-serial transmitter for external shift-register output chips (74HC595-style):

---
 rtl/shift_out_pkg.sv | 22 ++
 rtl/sck_phase_counter.sv | 40 ++++
 rtl/shift_out_tx.sv | 136 +++++++++++++
 tb/tb_shift_out_tx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_out_pkg.sv
// Shared types and elaboration helpers for the 74HC595-style serial output transmitter.
package shift_out_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_LATCH
   } state_t;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DIV   = 4;

   // Counter width that stays at least one bit even when the count range collapses to 0..0.
   function automatic int cntWidth(input int n);
      return ($clog2(n) > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit paramsValid(input int width, input int div);
      return (width >= 1) && (div >= 1);
   endfunction

endpackage

// File: rtl/sck_phase_counter.sv
// Divider that marks the end of each SCK half-period: tick_o pulses on every DIV-th enabled cycle.
module sck_phase_counter
   import shift_out_pkg::*;
#(
   parameter int DIV = DEFAULT_DIV
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int            CW   = cntWidth(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] divcnt_q;
   logic [CW-1:0] divcnt_d;

   // Explicit return to zero at the terminal count so no DIV value depends on counter overflow.
   always_comb begin
      divcnt_d = divcnt_q;
      if (clr_i) begin
         divcnt_d = '0;
      end else if (en_i) begin
         divcnt_d = (divcnt_q == LAST) ? '0 : divcnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         divcnt_q <= '0;
      end else begin
         divcnt_q <= divcnt_d;
      end
   end

   assign tick_o = en_i & ~clr_i & (divcnt_q == LAST);

endmodule

// File: rtl/shift_out_tx.sv
// Parallel-to-serial transmitter for 595-style output chips: accepts a word, shifts it out
// MSB first on sdo_o/sck_o, then strobes latch_o for DIV cycles.
module shift_out_tx
   import shift_out_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DIV   = DEFAULT_DIV
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             sdo_o,
   output logic             sck_o,
   output logic             latch_o
);

   localparam int            BW       = $clog2(WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   if (!paramsValid(WIDTH, DIV)) begin : gBadParams
      $error("shift_out_tx: WIDTH and DIV must both be >= 1");
   end

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] shreg_q,  shreg_d;
   logic [BW-1:0]    bitcnt_q, bitcnt_d;
   logic             ready_q,  ready_d;
   logic             sdo_q,    sdo_d;
   logic             sck_q,    sck_d;
   logic             latch_q,  latch_d;

   logic             accept;
   logic             divEn;
   logic             tick;
   logic [WIDTH-1:0] shifted;

   assign accept  = valid_i & ready_q;
   assign divEn   = (state_q != S_IDLE);
   assign shifted = shreg_q << 1;

   sck_phase_counter #(
      .DIV (DIV)
   ) uPhase (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (divEn),
      .clr_i  (accept),
      .tick_o (tick)
   );

   // Each tick ends a half-period; sdo only moves on the high-to-low tick so it is stable while SCK is high.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      ready_d  = ready_q;
      sdo_d    = sdo_q;
      sck_d    = sck_q;
      latch_d  = latch_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d  = S_SHIFT;
               shreg_d  = data_i;
               ready_d  = 1'b0;
               sdo_d    = data_i[WIDTH-1];
               sck_d    = 1'b0;
               bitcnt_d = '0;
            end
         end

         S_SHIFT: begin
            if (tick) begin
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else if (bitcnt_q == LAST_BIT) begin
                  state_d = S_LATCH;
                  sck_d   = 1'b0;
                  sdo_d   = 1'b0;
                  latch_d = 1'b1;
               end else begin
                  sck_d    = 1'b0;
                  shreg_d  = shifted;
                  sdo_d    = shifted[WIDTH-1];
                  bitcnt_d = bitcnt_q + BW'(1);
               end
            end
         end

         S_LATCH: begin
            if (tick) begin
               state_d = S_IDLE;
               latch_d = 1'b0;
               ready_d = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            sdo_d   = 1'b0;
            sck_d   = 1'b0;
            latch_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         ready_q  <= 1'b1;
         sdo_q    <= 1'b0;
         sck_q    <= 1'b0;
         latch_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         ready_q  <= ready_d;
         sdo_q    <= sdo_d;
         sck_q    <= sck_d;
         latch_q  <= latch_d;
      end
   end

   assign ready_o = ready_q;
   assign sdo_o   = sdo_q;
   assign sck_o   = sck_q;
   assign latch_o = latch_q;

endmodule

// File: tb/tb_shift_out_tx.sv
// Self-checking bench for shift_out_tx: a cycle-timeline model of the pin waveform plus a
// behavioural 595 chip, exercised on a default instance and a DIV=1/WIDTH=1 instance.
module tb_shift_out_tx;

   localparam int WA    = 8;
   localparam int DA    = 4;
   localparam int WB    = 1;
   localparam int DB    = 1;
   localparam int SPANA = 2 * DA * WA + DA;
   localparam int SPANB = 2 * DB * WB + DB;

   logic          clk = 1'b0;
   logic          rst = 1'b0;

   logic [WA-1:0] dataA  = '0;
   logic          validA = 1'b0;
   logic          readyA, sdoA, sckA, latchA;

   logic [WB-1:0] dataB  = '0;
   logic          validB = 1'b0;
   logic          readyB, sdoB, sckB, latchB;

   int            checks   = 0;
   int            errors   = 0;
   int            cyc      = 0;
   bit            checking = 1'b0;

   always #5 clk = ~clk;

   shift_out_tx #(.WIDTH(WA), .DIV(DA)) dutA (
      .clk_i   (clk),
      .rst_i   (rst),
      .data_i  (dataA),
      .valid_i (validA),
      .ready_o (readyA),
      .sdo_o   (sdoA),
      .sck_o   (sckA),
      .latch_o (latchA)
   );

   shift_out_tx #(.WIDTH(WB), .DIV(DB)) dutB (
      .clk_i   (clk),
      .rst_i   (rst),
      .data_i  (dataB),
      .valid_i (validB),
      .ready_o (readyB),
      .sdo_o   (sdoB),
      .sck_o   (sckB),
      .latch_o (latchB)
   );

   task automatic checkOutput(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Expected pins {ready, sck, sdo, latch} t cycles after the accept edge of `word`.
   function automatic logic [3:0] expPins(input bit busy, input int t, input logic [7:0] word,
                                          input int w, input int d);
      int bitIdx;
      if (!busy) return 4'b1000;
      if (t < 2 * d * w) begin
         bitIdx = t / (2 * d);
         return {1'b0, ((t % (2 * d)) >= d), word[w - 1 - bitIdx], 1'b0};
      end
      return 4'b0001;
   endfunction

   // Transaction-level model: idle or busy with a cycle offset since the accept edge.
   bit          mBusyA = 1'b0, mBusyB = 1'b0;
   int          mTA = 0, mTB = 0;
   logic [7:0]  mWordA = '0, mWordB = '0;
   int          acceptCntA = 0, lastAcceptA = 0, prevAcceptA = 0;

   always @(posedge rst) begin
      mBusyA = 1'b0;
      mBusyB = 1'b0;
   end

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         mBusyA = 1'b0;
         mBusyB = 1'b0;
      end else begin
         if (mBusyA) begin
            mTA++;
            if (mTA >= SPANA) mBusyA = 1'b0;
         end else if (validA) begin
            mBusyA      = 1'b1;
            mTA         = 0;
            mWordA      = dataA;
            prevAcceptA = lastAcceptA;
            lastAcceptA = cyc;
            acceptCntA++;
         end
         if (mBusyB) begin
            mTB++;
            if (mTB >= SPANB) mBusyB = 1'b0;
         end else if (validB) begin
            mBusyB = 1'b1;
            mTB    = 0;
            mWordB = {7'b0, dataB};
         end
      end
   end

   // Per-cycle comparison of both instances against the model, plus a 595 chip model on instance A.
   logic [7:0]  chipSrA = '0;
   logic [7:0]  latchedA[$];
   bit          prevSckA = 1'b0, prevLatchA = 1'b0, prevReadyA = 1'b1, prevSdoA = 1'b0;
   bit          prevSckB = 1'b0, prevSdoB = 1'b0;
   int          latchRiseCycA = 0, latchWidthA = 0, readyRiseCycA = 0;

   always @(negedge clk) begin
      if (checking) begin
         checkOutput("pinsA", int'({readyA, sckA, sdoA, latchA}),
                     int'(expPins(mBusyA, mTA, mWordA, WA, DA)));
         checkOutput("pinsB", int'({readyB, sckB, sdoB, latchB}),
                     int'(expPins(mBusyB, mTB, mWordB, WB, DB)));
         if (prevSckA && sckA) checkOutput("sdoStableA", int'(sdoA), int'(prevSdoA));
         if (prevSckB && sckB) checkOutput("sdoStableB", int'(sdoB), int'(prevSdoB));
      end
      if (sckA && !prevSckA) chipSrA = {chipSrA[6:0], sdoA};
      if (latchA && !prevLatchA) begin
         latchedA.push_back(chipSrA);
         latchRiseCycA = cyc;
      end
      if (!latchA && prevLatchA) latchWidthA = cyc - latchRiseCycA;
      if (readyA && !prevReadyA) readyRiseCycA = cyc;
      prevSckA   = sckA;
      prevLatchA = latchA;
      prevReadyA = readyA;
      prevSdoA   = sdoA;
      prevSckB   = sckB;
      prevSdoB   = sdoB;
   end

   task automatic waitReadyA();
      int n = 0;
      while (!readyA && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!readyA) checkOutput("readyTimeoutA", int'(readyA), 1);
   endtask

   task automatic applyStimulus(input logic [7:0] w);
      waitReadyA();
      dataA  = w;
      validA = 1'b1;
      @(posedge clk);
      #1 validA = 1'b0;
   endtask

   task automatic waitAccepts(input int target);
      int n = 0;
      while (acceptCntA < target && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (acceptCntA < target) checkOutput("acceptTimeoutA", acceptCntA, target);
   endtask

   initial begin
      int          nLatched;
      int          c0;
      int          sckHi, sckHiSdo, latHi, busyCnt;
      logic [7:0]  w;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checking = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("resetPinsA", int'({readyA, sckA, sdoA, latchA}), 4'b1000);
      checkOutput("resetPinsB", int'({readyB, sckB, sdoB, latchB}), 4'b1000);

      // Reset in the middle of a frame abandons it without a latch pulse.
      @(posedge clk);
      #1;
      applyStimulus(8'h3C);
      repeat (20) @(posedge clk);
      nLatched = latchedA.size();
      #1 rst = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("midResetPinsA", int'({readyA, sckA, sdoA, latchA}), 4'b1000);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (80) @(posedge clk);
      #1;
      checkOutput("noLatchAfterReset", latchedA.size(), nLatched);

      // Single default frame with hand-computed timing.
      applyStimulus(8'hA5);
      waitReadyA();
      @(negedge clk);
      #1;
      checkOutput("frameA5Word", int'(latchedA[$]), 8'hA5);
      checkOutput("latchStartOffset", latchRiseCycA - lastAcceptA, 64);
      checkOutput("latchWidth", latchWidthA, 4);
      checkOutput("readyReturnOffset", readyRiseCycA - lastAcceptA, 68);

      // Back-to-back frames with VALID held high.
      waitReadyA();
      c0     = acceptCntA;
      dataA  = 8'hFF;
      validA = 1'b1;
      waitAccepts(c0 + 1);
      dataA = 8'h00;
      waitAccepts(c0 + 2);
      validA = 1'b0;
      checkOutput("backToBackPeriod", lastAcceptA - prevAcceptA, 69);
      waitReadyA();
      @(negedge clk);
      #1;
      checkOutput("chipOutFirst", int'(latchedA[latchedA.size() - 2]), 8'hFF);
      checkOutput("chipOutSecond", int'(latchedA[$]), 8'h00);

      // VALID and I scrambled while busy must not disturb the frame in flight.
      c0 = acceptCntA;
      applyStimulus(8'h5A);
      for (int i = 0; i < 50; i++) begin
         validA = 1'($urandom_range(0, 1));
         dataA  = 8'($urandom);
         @(posedge clk);
         #1;
      end
      validA = 1'b0;
      waitReadyA();
      @(negedge clk);
      #1;
      checkOutput("busyIgnoredWord", int'(latchedA[$]), 8'h5A);
      checkOutput("busyIgnoredAccepts", acceptCntA, c0 + 1);

      // DIV=1, WIDTH=1 corner: one SCK-high cycle, one latch cycle, three busy cycles.
      sckHi    = 0;
      sckHiSdo = 0;
      latHi    = 0;
      busyCnt  = 0;
      dataB    = 1'b1;
      validB   = 1'b1;
      @(posedge clk);
      #1 validB = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (sckB) sckHi++;
         if (sckB && sdoB) sckHiSdo++;
         if (latchB) latHi++;
         if (!readyB) busyCnt++;
      end
      checkOutput("tinySckHigh", sckHi, 1);
      checkOutput("tinySckHighSdo", sckHiSdo, 1);
      checkOutput("tinyLatch", latHi, 1);
      checkOutput("tinyBusy", busyCnt, 3);

      // Random frames: per-cycle model checks and the SDO stability check run throughout.
      @(posedge clk);
      #1;
      for (int f = 0; f < 5; f++) begin
         w = 8'($urandom);
         applyStimulus(w);
         waitReadyA();
         @(negedge clk);
         #1;
         checkOutput("randomFrameWord", int'(latchedA[$]), int'(w));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
